cpu_ctrl_seq: RTL

- Multi-cycle control sequencer for the 4-bit-opcode CPU datapath (instruction format {op[31:28], rd[27:24], ra[23:20], rb[19:16], imm[15:0]}).
- Fetches instructions over an instruction-memory request/ack handshake and holds them in the instruction register feeding the datapath.
- Sequences register-file writes, branch PC updates and data-memory load/store handshakes.
- Keeps a retired-instruction counter and flags bus timeouts and illegal opcodes.

---
 rtl/cpu_ctrl_seq_if.sv | 31 +++
 rtl/cpu_ctrl_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_seq_if.sv
// Instruction- and data-memory handshake bundle between the control sequencer and memory.
// The sequencer drives requests; memory drives acks and fetched data.
interface cpu_ctrl_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  imem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output imem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/wb with bus timeouts,
// retired-instruction counting and illegal-opcode flagging. All outputs are registered.
module cpu_ctrl_seq #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_ctrl_seq_if.master        bus,
  output logic [31:0]           ir,
  output logic [31:0]           pc,
  input  logic                  eq,
  output logic                  rf_wr_en,
  output logic                  wb_sel,
  output logic                  halted,
  output logic                  bus_err,
  output logic                  illegal,
  output logic [31:0]           retired
);

  typedef enum logic [2:0] {
    StRst,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [3:0] OpIllegal = 4'b0111;
  localparam logic [3:0] OpBeq     = 4'b1000;
  localparam logic [3:0] OpLw      = 4'b1001;
  localparam logic [3:0] OpSw      = 4'b1010;
  localparam logic [3:0] OpHalt    = 4'b1111;

  // Last wait count at which an ack is still accepted.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] retired_q;
  logic [7:0]  wait_q;
  logic        bus_err_q;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic        rf_wr_en_q;
  logic        wb_sel_q;
  logic        halted_q;
  logic        illegal_q;

  logic [3:0]  op;
  logic [31:0] pc_inc;
  logic [31:0] br_off;

  assign op     = ir_q[31:28];
  assign pc_inc = pc_q + 32'd4;
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  function automatic logic writes_rd(input logic [3:0] opc);
    return opc inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                       4'b0110, 4'b1011, 4'b1100, 4'b1101};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRst;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      retired_q  <= '0;
      wait_q     <= '0;
      bus_err_q  <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_wr_en_q <= 1'b0;
      wb_sel_q   <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      // Strobes are one-cycle unless the next state re-asserts them.
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_wr_en_q <= 1'b0;
      wb_sel_q   <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;

      unique case (state_q)
        StRst: begin
          state_q    <= StFetch;
          wait_q     <= '0;
          imem_req_q <= 1'b1;
        end

        StFetch: begin
          if (bus.imem_ack) begin
            ir_q    <= bus.imem_rdata;
            state_q <= StDecode;
          end else if (wait_q == WaitLast) begin
            bus_err_q <= 1'b1;
            halted_q  <= 1'b1;
            state_q   <= StHalt;
          end else begin
            wait_q     <= wait_q + 8'd1;
            imem_req_q <= 1'b1;
          end
        end

        StDecode: begin
          state_q    <= StExec;
          rf_wr_en_q <= writes_rd(op);
          illegal_q  <= (op == OpIllegal);
        end

        StExec: begin
          unique case (op)
            OpLw, OpSw: begin
              state_q    <= StMem;
              wait_q     <= '0;
              dmem_req_q <= 1'b1;
              dmem_we_q  <= (op == OpSw);
            end
            OpHalt: begin
              state_q   <= StHalt;
              retired_q <= retired_q + 32'd1;
              halted_q  <= 1'b1;
            end
            OpBeq: begin
              pc_q       <= eq ? (pc_inc + br_off) : pc_inc;
              retired_q  <= retired_q + 32'd1;
              state_q    <= StFetch;
              wait_q     <= '0;
              imem_req_q <= 1'b1;
            end
            default: begin
              // ALU/immediate ops and illegal opcodes (treated as NOP) retire alike.
              pc_q       <= pc_inc;
              retired_q  <= retired_q + 32'd1;
              state_q    <= StFetch;
              wait_q     <= '0;
              imem_req_q <= 1'b1;
            end
          endcase
        end

        StMem: begin
          if (bus.dmem_ack) begin
            if (op == OpSw) begin
              pc_q       <= pc_inc;
              retired_q  <= retired_q + 32'd1;
              state_q    <= StFetch;
              wait_q     <= '0;
              imem_req_q <= 1'b1;
            end else begin
              state_q    <= StWb;
              rf_wr_en_q <= 1'b1;
              wb_sel_q   <= 1'b1;
            end
          end else if (wait_q == WaitLast) begin
            bus_err_q <= 1'b1;
            halted_q  <= 1'b1;
            state_q   <= StHalt;
          end else begin
            wait_q     <= wait_q + 8'd1;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (op == OpSw);
          end
        end

        StWb: begin
          pc_q       <= pc_inc;
          retired_q  <= retired_q + 32'd1;
          state_q    <= StFetch;
          wait_q     <= '0;
          imem_req_q <= 1'b1;
        end

        StHalt: begin
          halted_q <= 1'b1;
        end

        default: begin
          state_q <= StRst;
        end
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_we_q;
  assign ir            = ir_q;
  assign pc            = pc_q;
  assign rf_wr_en      = rf_wr_en_q;
  assign wb_sel        = wb_sel_q;
  assign halted        = halted_q;
  assign bus_err       = bus_err_q;
  assign illegal       = illegal_q;
  assign retired       = retired_q;

endmodule
